flow_rr_scheduler: RTL and testbench

- Read-side packet scheduler for the multichannel segment buffer.
- Keeps a per-flow count of complete packets committed by the write side.
- Selects one flow at a time by packet-atomic round-robin and holds that grant until the read datapath reports the granted packet's last beat.
- Sits between the buffer's write-commit logic and its read controller, which uses grant_flow to pick the flow linked list to drain.

---
 rtl/flow_rr_scheduler_if.sv | 27 ++
 rtl/flow_rr_scheduler.sv | 117 +++++++++++
 tb/tb_flow_rr_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flow_rr_scheduler_if.sv
// Handshake bundle between the buffer write-commit/read logic and the packet scheduler.
// master = buffer side (commits, completions, enables); slave = scheduler.
interface flow_rr_scheduler_if #(
    parameter int FLOWS_W = 3
);
    localparam int NUM_FLOWS = 2**FLOWS_W;

    logic                 wr_pkt_done;
    logic [FLOWS_W-1:0]   wr_pkt_flow;
    logic [NUM_FLOWS-1:0] flow_en;
    logic                 rd_pkt_done;
    logic                 grant_valid;
    logic [FLOWS_W-1:0]   grant_flow;
    logic [NUM_FLOWS-1:0] pkt_pending;
    logic                 err_ovf;
    logic                 err_unexp;

    modport master (
        output wr_pkt_done, wr_pkt_flow, flow_en, rd_pkt_done,
        input  grant_valid, grant_flow, pkt_pending, err_ovf, err_unexp
    );

    modport slave (
        input  wr_pkt_done, wr_pkt_flow, flow_en, rd_pkt_done,
        output grant_valid, grant_flow, pkt_pending, err_ovf, err_unexp
    );
endinterface

// File: rtl/flow_rr_scheduler.sv
// Packet-atomic round-robin scheduler: per-flow committed-packet counters feeding
// a two-state arbiter that holds each grant until the packet's last beat is read.

module flow_rr_cnt #(
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic pending,
    output logic ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // A commit landing on a saturated count is dropped and flagged.
    assign ovf     = inc & ~dec & (cnt == CNT_MAX);
    assign pending = |cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

module flow_rr_scheduler #(
    parameter int FLOWS_W = 3,
    parameter int CNT_W   = 6
) (
    input logic                clk,
    input logic                rst,
    flow_rr_scheduler_if.slave bus
);
    localparam int NUM_FLOWS = 2**FLOWS_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [FLOWS_W-1:0]   rr_ptr;
    logic [FLOWS_W-1:0]   grant_flow;
    logic                 grant_valid;
    logic                 err_ovf;
    logic                 err_unexp;
    logic [NUM_FLOWS-1:0] inc, dec, pend, ovf_v, eligible;
    logic [FLOWS_W-1:0]   pick, idx;
    logic                 found;
    logic                 grant_now;

    assign inc      = bus.wr_pkt_done ? (NUM_FLOWS'(1) << bus.wr_pkt_flow) : '0;
    assign dec      = grant_now ? (NUM_FLOWS'(1) << pick) : '0;
    assign eligible = pend & bus.flow_en;

    flow_rr_cnt #(.CNT_W(CNT_W)) u_cnt [NUM_FLOWS-1:0] (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .pending (pend),
        .ovf     (ovf_v)
    );

    // Search starts just past the last-served flow; i == NUM_FLOWS wraps to rr_ptr itself.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_FLOWS; i++) begin
            idx = rr_ptr + FLOWS_W'(i);
            if (!found && eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign grant_now = (state == IDLE) && found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_flow  <= '0;
            rr_ptr      <= '1;
            err_ovf     <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            if (|ovf_v) err_ovf <= 1'b1;
            if (bus.rd_pkt_done && state == IDLE) err_unexp <= 1'b1;
            case (state)
                IDLE: if (found) begin
                    grant_flow  <= pick;
                    grant_valid <= 1'b1;
                    state       <= BUSY;
                end
                BUSY: if (bus.rd_pkt_done) begin
                    grant_valid <= 1'b0;
                    rr_ptr      <= grant_flow;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_valid = grant_valid;
    assign bus.grant_flow  = grant_flow;
    assign bus.pkt_pending = pend;
    assign bus.err_ovf     = err_ovf;
    assign bus.err_unexp   = err_unexp;
endmodule

// File: tb/tb_flow_rr_scheduler.sv
// Bench for flow_rr_scheduler: directed scenarios plus a randomized run checked
// against a per-cycle packet-count model kept here.
module tb_flow_rr_scheduler;
    localparam int FW = 3, NF = 8, CW = 6, CMAX = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flow_rr_scheduler_if #(.FLOWS_W(FW)) bus ();
    flow_rr_scheduler #(.FLOWS_W(FW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0, n_fail = 0;

    // Reference state: packet counts per flow, who holds the grant, last served flow.
    int m_cnt[NF];
    bit m_busy, m_ovf, m_unexp;
    int m_gf, m_rr;

    function automatic logic [NF-1:0] m_pend();
        logic [NF-1:0] p;
        p = '0;
        for (int f = 0; f < NF; f++) p[f] = (m_cnt[f] != 0);
        return p;
    endfunction

    task automatic tick();
        int g, w;
        @(posedge clk);
        if (rst) begin
            for (int f = 0; f < NF; f++) m_cnt[f] = 0;
            m_busy = 0; m_gf = 0; m_rr = NF - 1; m_ovf = 0; m_unexp = 0;
        end else begin
            g = -1;
            if (!m_busy)
                for (int k = 1; k <= NF; k++) begin
                    int f;
                    f = (m_rr + k) % NF;
                    if (g < 0 && m_cnt[f] != 0 && bus.flow_en[f]) g = f;
                end
            if (bus.rd_pkt_done) begin
                if (m_busy) begin m_busy = 0; m_rr = m_gf; end
                else m_unexp = 1;
            end
            if (g >= 0) begin m_busy = 1; m_gf = g; m_cnt[g]--; end
            if (bus.wr_pkt_done) begin
                w = int'(bus.wr_pkt_flow);
                if (w == g) m_cnt[w]++;
                else if (m_cnt[w] == CMAX) m_ovf = 1;
                else m_cnt[w]++;
            end
        end
        #1;
        bus.wr_pkt_done = 1'b0;
        bus.rd_pkt_done = 1'b0;
    endtask

    task automatic commit(input int f);
        bus.wr_pkt_done = 1'b1;
        bus.wr_pkt_flow = FW'(f);
        tick();
    endtask

    task automatic wait_grant(output int f, output bit ok);
        ok = 0; f = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.grant_valid) begin ok = 1; f = int'(bus.grant_flow); break; end
            tick();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.flow_en = 8'hFF;
        commit(2); commit(5);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv got=%b exp=0", bus.grant_valid); end
        n_chk++; if (bus.grant_flow !== 3'd0) begin n_fail++; $display("FAIL reset_gf got=%0d exp=0", bus.grant_flow); end
        n_chk++; if (bus.pkt_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pend got=%h exp=00", bus.pkt_pending); end
        n_chk++; if ({bus.err_ovf, bus.err_unexp} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b%b exp=00", bus.err_ovf, bus.err_unexp); end
    endtask

    task automatic test_single();
        reset_dut();
        bus.flow_en = 8'hFF;
        commit(5);
        n_chk++; if (bus.pkt_pending !== 8'h20 || bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1 pend=%h gv=%b exp pend=20 gv=0", bus.pkt_pending, bus.grant_valid); end
        tick();
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd5) begin n_fail++; $display("FAIL single_n2 gv=%b gf=%0d exp gv=1 gf=5", bus.grant_valid, bus.grant_flow); end
        tick();
        n_chk++; if (bus.pkt_pending !== 8'h00 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_n3 pend=%h gv=%b exp pend=00 gv=1", bus.pkt_pending, bus.grant_valid); end
        bus.rd_pkt_done = 1'b1; tick();
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_done gv=%b exp=0", bus.grant_valid); end
    endtask

    task automatic test_round_robin();
        int exp_o[6] = '{1, 3, 6, 1, 3, 6};
        int f; bit ok;
        reset_dut();
        bus.flow_en = 8'h00;
        for (int j = 0; j < 6; j++) commit(exp_o[j]);
        bus.flow_en = 8'hFF;
        for (int j = 0; j < 6; j++) begin
            wait_grant(f, ok);
            n_chk++; if (!ok || f != exp_o[j]) begin n_fail++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d ok=%b", j, f, exp_o[j], ok); end
            tick(); tick(); tick();
            bus.rd_pkt_done = 1'b1; tick();
            n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap idx=%0d gv=%b exp=0", j, bus.grant_valid); end
        end
        tick(); tick();
        n_chk++; if (bus.pkt_pending !== 8'h00 || bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_final pend=%h gv=%b exp pend=00 gv=0", bus.pkt_pending, bus.grant_valid); end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        bus.flow_en = 8'hFF;
        commit(2);
        commit(2);
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd2 || bus.pkt_pending !== 8'h04) begin n_fail++; $display("FAIL simul_grant gv=%b gf=%0d pend=%h exp gv=1 gf=2 pend=04", bus.grant_valid, bus.grant_flow, bus.pkt_pending); end
        bus.rd_pkt_done = 1'b1; tick();
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL simul_idle gv=%b exp=0", bus.grant_valid); end
        tick();
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd2 || bus.pkt_pending !== 8'h00) begin n_fail++; $display("FAIL simul_regrant gv=%b gf=%0d pend=%h exp gv=1 gf=2 pend=00", bus.grant_valid, bus.grant_flow, bus.pkt_pending); end
        bus.rd_pkt_done = 1'b1; tick();
    endtask

    task automatic test_mask();
        reset_dut();
        bus.flow_en = 8'hFE;
        commit(0);
        commit(4);
        tick();
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd4) begin n_fail++; $display("FAIL mask_grant gv=%b gf=%0d exp gv=1 gf=4", bus.grant_valid, bus.grant_flow); end
        bus.flow_en = 8'hFF;
        tick(); tick();
        n_chk++; if (bus.grant_flow !== 3'd4 || bus.pkt_pending !== 8'h01) begin n_fail++; $display("FAIL mask_hold gf=%0d pend=%h exp gf=4 pend=01", bus.grant_flow, bus.pkt_pending); end
        bus.rd_pkt_done = 1'b1; tick();
        tick();
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd0) begin n_fail++; $display("FAIL mask_unmask gv=%b gf=%0d exp gv=1 gf=0", bus.grant_valid, bus.grant_flow); end
        bus.rd_pkt_done = 1'b1; tick();
    endtask

    task automatic test_overflow_errors();
        int f, n; bit ok;
        reset_dut();
        bus.flow_en = 8'h7F;
        for (int i = 0; i < 64; i++) commit(7);
        n_chk++; if (bus.err_ovf !== 1'b1 || bus.err_unexp !== 1'b0) begin n_fail++; $display("FAIL ovf_flag ovf=%b unexp=%b exp ovf=1 unexp=0", bus.err_ovf, bus.err_unexp); end
        n_chk++; if (bus.pkt_pending !== 8'h80 || bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_state pend=%h gv=%b exp pend=80 gv=0", bus.pkt_pending, bus.grant_valid); end
        bus.rd_pkt_done = 1'b1; tick();
        n_chk++; if (bus.err_unexp !== 1'b1 || bus.pkt_pending !== 8'h80 || bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL unexp unexp=%b pend=%h gv=%b exp unexp=1 pend=80 gv=0", bus.err_unexp, bus.pkt_pending, bus.grant_valid); end
        bus.flow_en = 8'hFF;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            wait_grant(f, ok);
            if (!ok) break;
            n++;
            bus.rd_pkt_done = 1'b1; tick();
        end
        n_chk++; if (n != CMAX) begin n_fail++; $display("FAIL ovf_drain grants=%0d exp=%0d", n, CMAX); end
        n_chk++; if (bus.err_ovf !== 1'b1 || bus.err_unexp !== 1'b1) begin n_fail++; $display("FAIL err_sticky ovf=%b unexp=%b exp 1 1", bus.err_ovf, bus.err_unexp); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.flow_en = 8'hFF;
        commit(3); commit(3); commit(3);
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre gv=%b gf=%0d exp gv=1 gf=3", bus.grant_valid, bus.grant_flow); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_chk++; if ({bus.grant_valid, bus.grant_flow, bus.pkt_pending, bus.err_ovf, bus.err_unexp} !== 14'd0) begin n_fail++; $display("FAIL rstmid_clr gv=%b gf=%0d pend=%h ovf=%b unexp=%b exp all 0", bus.grant_valid, bus.grant_flow, bus.pkt_pending, bus.err_ovf, bus.err_unexp); end
        tick();
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_nogrant gv=%b exp=0", bus.grant_valid); end
        commit(0); tick();
        n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_flow !== 3'd0) begin n_fail++; $display("FAIL rstmid_new gv=%b gf=%0d exp gv=1 gf=0", bus.grant_valid, bus.grant_flow); end
    endtask

    task automatic test_random();
        int bad;
        reset_dut();
        bus.flow_en = 8'hFF;
        bad = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) bus.flow_en = NF'($urandom);
            bus.wr_pkt_done = 1'($urandom_range(0, 1));
            bus.wr_pkt_flow = FW'($urandom_range(0, NF - 1));
            bus.rd_pkt_done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
            tick();
            n_chk++;
            if (bus.grant_valid !== m_busy || int'(bus.grant_flow) != m_gf || bus.pkt_pending !== m_pend()
                || bus.err_ovf !== m_ovf || bus.err_unexp !== m_unexp) begin
                n_fail++;
                if (bad++ < 10) $display("FAIL rand cyc=%0d gv=%b/%b gf=%0d/%0d pend=%h/%h ovf=%b/%b unexp=%b/%b (got/exp)", c,
                    bus.grant_valid, m_busy, bus.grant_flow, m_gf, bus.pkt_pending, m_pend(), bus.err_ovf, m_ovf, bus.err_unexp, m_unexp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_pkt_done = 1'b0;
        bus.wr_pkt_flow = '0;
        bus.flow_en     = '0;
        bus.rd_pkt_done = 1'b0;
        #1;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_simultaneous();
        test_mask();
        test_overflow_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
